fraction_result_collector: RTL and testbench

//  Downstream stage of the 4-bit fractional add-shift multiplier. Captures each finished
//  7-bit Q1.6 two's-complement Product on the rising edge of the multiplier's Done.

---
 rtl/fraction_result_collector.sv | 88 ++++++++
 tb/tb_fraction_result_collector.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fraction_result_collector.sv
// Queues reduced multiplier results on Done rise; one-edge capture latency, show-ahead valid/ready head.
// Full FIFO drops new captures and sets sticky Ovf; define FRAC_RESULT_ROUND_EN for round-half-up with saturation.
module fraction_result_collector #(
  parameter int DEPTH = 4,
  parameter int PW    = 7,
  parameter int RW    = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       Done,
  input  logic [PW-1:0]              Product,
  input  logic                       Res_Ready,
  input  logic                       Ovf_Clr,
  output logic                       Res_Valid,
  output logic [RW-1:0]              Res_Data,
  output logic [PW-1:0]              Res_Full,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       Ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [RW-1:0] res_mem  [DEPTH];
  logic [PW-1:0] prod_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          done_q;
  logic          cap, pop, full, wr_en, drop;
  logic [RW-1:0] red;

  assign cap       = Done & ~done_q;
  assign Res_Valid = (Count != '0);
  assign pop       = Res_Valid & Res_Ready;
  assign full      = (Count == CW'(DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the capture.
  assign wr_en     = cap & (~full | pop);
  assign drop      = cap & full & ~pop;

`ifdef FRAC_RESULT_ROUND_EN
  logic [RW-1:0] t;
  always_comb begin
    t   = Product[PW-1:PW-RW] + RW'(Product[PW-RW-1]);
    red = t;
    // Only a positive value can round past the top of the range.
    if (!Product[PW-1] && t[RW-1])
      red = {1'b0, {(RW-1){1'b1}}};
  end
`else
  always_comb begin
    red = Product[PW-1:PW-RW];
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      done_q <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
      Ovf    <= 1'b0;
    end else begin
      done_q <= Done;
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !pop)
        Count <= Count + CW'(1);
      else if (pop && !wr_en)
        Count <= Count - CW'(1);
      if (drop)
        Ovf <= 1'b1;
      else if (Ovf_Clr)
        Ovf <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      res_mem[wr_ptr]  <= red;
      prod_mem[wr_ptr] <= Product;
    end
  end

  assign Res_Data = res_mem[rd_ptr];
  assign Res_Full = prod_mem[rd_ptr];

endmodule

// File: tb/tb_fraction_result_collector.sv
// Scoreboard bench for fraction_result_collector at default parameters, either rounding build.
module tb_fraction_result_collector;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Done;
  logic [6:0] Product;
  logic       Res_Ready;
  logic       Ovf_Clr;
  logic       Res_Valid;
  logic [3:0] Res_Data;
  logic [6:0] Res_Full;
  logic [2:0] Count;
  logic       Ovf;

  int n_vec = 0;
  int n_err = 0;
  logic [10:0] sb [$];

  fraction_result_collector #(.DEPTH(4), .PW(7), .RW(4)) dut (
    .CLK(CLK), .RST(RST), .Done(Done), .Product(Product),
    .Res_Ready(Res_Ready), .Ovf_Clr(Ovf_Clr), .Res_Valid(Res_Valid),
    .Res_Data(Res_Data), .Res_Full(Res_Full), .Count(Count), .Ovf(Ovf)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference reduction as signed arithmetic on the Q1.6 value.
  function automatic logic [3:0] model_red(input logic [6:0] p);
    int v;
    v = int'($signed(p));
`ifdef FRAC_RESULT_ROUND_EN
    v = (v + 4) >>> 3;
    if (v > 7) v = 7;
`else
    v = v >>> 3;
`endif
    return v[3:0];
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One-cycle Done pulse; the expected entry is queued only if the model has room.
  task automatic pulse(input logic [6:0] p);
    Done = 1'b1; Product = p;
    tick();
    Done = 1'b0;
    tick();
    if (sb.size() < 4) sb.push_back({model_red(p), p});
  endtask

  task automatic drain_one(input string tag);
    logic [10:0] e;
    e = sb.pop_front();
    chk({tag, "_vld"},  32'(Res_Valid), 32'(1));
    chk({tag, "_data"}, 32'(Res_Data),  32'(e[10:7]));
    chk({tag, "_full"}, 32'(Res_Full),  32'(e[6:0]));
    Res_Ready = 1'b1;
    tick();
    Res_Ready = 1'b0;
  endtask

  initial begin
    RST = 1'b1; Done = 1'b0; Product = '0; Res_Ready = 1'b0; Ovf_Clr = 1'b0;
    #3;
    chk("rst_vld",   32'(Res_Valid), 32'(0));
    chk("rst_count", 32'(Count),     32'(0));
    chk("rst_ovf",   32'(Ovf),       32'(0));
    tick(); tick();
    RST = 1'b0;
    tick();

    // Done held three cycles: single capture, visible one edge after the rise.
    Done = 1'b1; Product = 7'h1C;
    tick();
    chk("t2_latency", 32'(Res_Valid), 32'(1));
    tick(); tick();
    Done = 1'b0;
    tick();
    sb.push_back({model_red(7'h1C), 7'h1C});
    chk("t2_count", 32'(Count), 32'(1));
`ifdef FRAC_RESULT_ROUND_EN
    chk("t2_data_const", 32'(Res_Data), 32'(4'h4));
`else
    chk("t2_data_const", 32'(Res_Data), 32'(4'h3));
`endif
    drain_one("t2");
    chk("t2_empty", 32'(Count), 32'(0));

    pulse(7'h3F);
    pulse(7'h64);
    chk("t3_count", 32'(Count), 32'(2));
    chk("t3_sat_const", 32'(Res_Data), 32'(4'h7));
    drain_one("t3a");
`ifdef FRAC_RESULT_ROUND_EN
    chk("t3_neg_const", 32'(Res_Data), 32'(4'hD));
`else
    chk("t3_neg_const", 32'(Res_Data), 32'(4'hC));
`endif
    drain_one("t3b");

    // Overflow: fifth capture dropped.
    for (int i = 1; i <= 5; i++) pulse(7'(i));
    chk("t4_count", 32'(Count), 32'(4));
    chk("t4_ovf",   32'(Ovf),   32'(1));
    for (int i = 0; i < 4; i++) drain_one("t4_drain");
    chk("t4_empty", 32'(Count), 32'(0));
    chk("t4_ovf_held", 32'(Ovf), 32'(1));
    Ovf_Clr = 1'b1;
    tick();
    Ovf_Clr = 1'b0;
    chk("t4_ovf_clr", 32'(Ovf), 32'(0));

    // Full FIFO with simultaneous pop and capture.
    for (int i = 0; i < 4; i++) pulse(7'h11 + 7'(i));
    chk("t5_full", 32'(Count), 32'(4));
    chk("t5_head", 32'(Res_Full), 32'(7'h11));
    Done = 1'b1; Product = 7'h15; Res_Ready = 1'b1;
    tick();
    Done = 1'b0; Res_Ready = 1'b0;
    void'(sb.pop_front());
    sb.push_back({model_red(7'h15), 7'h15});
    tick();
    chk("t5_count", 32'(Count), 32'(4));
    chk("t5_ovf",   32'(Ovf),   32'(0));
    for (int i = 0; i < 4; i++) drain_one("t5_drain");

    // Asynchronous reset mid-cycle with a full FIFO and Ovf set.
    for (int i = 0; i < 5; i++) pulse(7'h30 + 7'(i));
    chk("t1_pre_ovf", 32'(Ovf), 32'(1));
    #2;
    RST = 1'b1;
    #1;
    chk("t1_vld",   32'(Res_Valid), 32'(0));
    chk("t1_count", 32'(Count),     32'(0));
    chk("t1_ovf",   32'(Ovf),       32'(0));
    sb.delete();
    tick();
    RST = 1'b0;
    tick();

    // Reset while Done high: no capture until a fresh rise.
    pulse(7'h21);
    pulse(7'h22);
    chk("t6_pre", 32'(Count), 32'(2));
    Done = 1'b1; Product = 7'h23; RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    tick(); tick(); tick();
    sb.delete();
    chk("t6_count", 32'(Count),     32'(0));
    chk("t6_vld",   32'(Res_Valid), 32'(0));
    Done = 1'b0;
    tick();
    Done = 1'b1; Product = 7'h2A;
    tick(); tick();
    Done = 1'b0;
    tick();
    sb.push_back({model_red(7'h2A), 7'h2A});
    chk("t6_one", 32'(Count), 32'(1));
    drain_one("t6");
    chk("t6_end", 32'(Count), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
